// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, packing slots and bank states for the FFT stage buffer.
// FFT_BUF_SAT_EN selects clamping requantization instead of wrap-around.
package fft_pkg;

  localparam int C_POINTS_DEF = 32;

  // Slot index of each component inside a packed {real,imag} word.
  localparam int C_RE_SLOT = 1;
  localparam int C_IM_SLOT = 0;

  localparam logic [1:0] BANK_EMPTY    = 2'd0;
  localparam logic [1:0] BANK_FILLING  = 2'd1;
  localparam logic [1:0] BANK_FULL     = 2'd2;
  localparam logic [1:0] BANK_DRAINING = 2'd3;

`ifdef FFT_BUF_SAT_EN
  localparam bit C_SAT_EN = 1'b1;
`else
  localparam bit C_SAT_EN = 1'b0;
`endif

  function automatic int mult_width(input int input_width, input int point_position);
    return 2 * input_width - point_position + 1;
  endfunction

endpackage

// File: rtl/fft_stage_buffer_if.sv
// rtl/fft_stage_buffer_if.sv - butterfly write beats and sample read port of the stage buffer.
interface fft_stage_buffer_if #(
  parameter int p_inputWidth    = 8,
  parameter int p_PointPosition = 3
);
  import fft_pkg::*;

  localparam int c_W = mult_width(p_inputWidth, p_PointPosition);

  logic                      i_valid;
  logic                      o_ready;
  logic [2*c_W-1:0]          i_r1_p, i_r1_m, i_r2_p, i_r2_m;
  logic [2*c_W-1:0]          i_r3_p, i_r3_m, i_r4_p, i_r4_m;
  logic                      o_frame_ready;
  logic                      i_rd_en;
  logic [2*p_inputWidth-1:0] o_rd_data;
  logic                      o_rd_valid;
  logic                      o_rd_last;
  logic                      o_sat;

  modport master (
    output i_valid, i_r1_p, i_r1_m, i_r2_p, i_r2_m, i_r3_p, i_r3_m, i_r4_p, i_r4_m, i_rd_en,
    input  o_ready, o_frame_ready, o_rd_data, o_rd_valid, o_rd_last, o_sat
  );

  modport slave (
    input  i_valid, i_r1_p, i_r1_m, i_r2_p, i_r2_m, i_r3_p, i_r3_m, i_r4_p, i_r4_m, i_rd_en,
    output o_ready, o_frame_ready, o_rd_data, o_rd_valid, o_rd_last, o_sat
  );

endinterface

// File: rtl/cplx_requant.sv
// rtl/cplx_requant.sv - narrows one complex value to p_inputWidth per component, point kept.
// FFT_BUF_SAT_EN clamps out-of-range components and raises o_sat; otherwise low bits wrap.
module cplx_requant
  import fft_pkg::*;
#(
  parameter int p_inputWidth = 8,
  parameter int p_wideWidth  = 14
) (
  input  logic [2*p_wideWidth-1:0]  i_cplx,
  output logic [2*p_inputWidth-1:0] o_cplx,
  output logic                      o_sat
);

  logic [p_wideWidth-1:0]  w_re, w_im;
  logic [p_inputWidth-1:0] w_re_q, w_im_q;
  logic                    w_re_sat, w_im_sat;

  // Returns {saturated, narrowed}; a value fits when its dropped bits all repeat the new sign bit.
  function automatic logic [p_inputWidth:0] requant(input logic [p_wideWidth-1:0] v);
    logic [p_wideWidth-p_inputWidth:0] hi;
    hi = v[p_wideWidth-1:p_inputWidth-1];
    if (!C_SAT_EN || hi == '0 || hi == '1) return {1'b0, v[p_inputWidth-1:0]};
    if (v[p_wideWidth-1]) return {1'b1, 1'b1, {(p_inputWidth-1){1'b0}}};
    return {1'b1, 1'b0, {(p_inputWidth-1){1'b1}}};
  endfunction

  assign w_re = i_cplx[C_RE_SLOT*p_wideWidth +: p_wideWidth];
  assign w_im = i_cplx[C_IM_SLOT*p_wideWidth +: p_wideWidth];

  assign {w_re_sat, w_re_q} = requant(w_re);
  assign {w_im_sat, w_im_q} = requant(w_im);

  always_comb begin
    o_cplx = '0;
    o_cplx[C_RE_SLOT*p_inputWidth +: p_inputWidth] = w_re_q;
    o_cplx[C_IM_SLOT*p_inputWidth +: p_inputWidth] = w_im_q;
  end

  assign o_sat = w_re_sat | w_im_sat;

endmodule

// File: rtl/fft_stage_buffer.sv
// rtl/fft_stage_buffer.sv - ping-pong frame buffer between FFT butterfly stages.
// FFT_BUF_SAT_EN enables saturating requantization and the sticky o_sat flag.
module fft_stage_buffer
  import fft_pkg::*;
#(
  parameter int p_inputWidth    = 8,
  parameter int p_PointPosition = 3,
  parameter int p_points        = C_POINTS_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  fft_stage_buffer_if.slave bus
);

  localparam int c_W    = mult_width(p_inputWidth, p_PointPosition);
  localparam int c_DW   = 2 * p_inputWidth;
  localparam int c_AW   = $clog2(p_points);
  localparam int c_NB   = p_points / 8;
  localparam int c_BW   = (c_NB > 1) ? $clog2(c_NB) : 1;
  localparam int c_HALF = p_points / 2;

  logic [c_DW-1:0] r_mem [2][p_points];
  logic [1:0]      r_state [2];
  logic            r_wr_bank, r_rd_bank;
  logic [c_BW-1:0] r_beat;
  logic [c_AW-1:0] r_rd_addr;
  logic            r_frame_ready, r_rd_valid, r_rd_last, r_sat;
  logic [c_DW-1:0] r_rd_data;

  logic [2*c_W-1:0] w_in [8];
  logic [c_DW-1:0]  w_q [8];
  logic [7:0]       w_sat;
  logic [c_AW-1:0]  w_base;
  logic             w_wr_blocked, w_wr, w_rd_avail, w_rd, w_last_beat, w_last_addr;

  // Slots 0..3 carry r1..r4 "plus" results, slots 4..7 the matching "minus" results.
  assign w_in[0] = bus.i_r1_p;
  assign w_in[1] = bus.i_r2_p;
  assign w_in[2] = bus.i_r3_p;
  assign w_in[3] = bus.i_r4_p;
  assign w_in[4] = bus.i_r1_m;
  assign w_in[5] = bus.i_r2_m;
  assign w_in[6] = bus.i_r3_m;
  assign w_in[7] = bus.i_r4_m;

  for (genvar g = 0; g < 8; g++) begin : g_req
    cplx_requant #(
      .p_inputWidth(p_inputWidth),
      .p_wideWidth (c_W)
    ) u_req (
      .i_cplx(w_in[g]),
      .o_cplx(w_q[g]),
      .o_sat (w_sat[g])
    );
  end

  assign w_wr_blocked = (r_state[r_wr_bank] == BANK_FULL) || (r_state[r_wr_bank] == BANK_DRAINING);
  assign w_wr         = bus.i_valid && !w_wr_blocked;
  assign w_rd_avail   = (r_state[r_rd_bank] == BANK_FULL) || (r_state[r_rd_bank] == BANK_DRAINING);
  assign w_rd         = bus.i_rd_en && w_rd_avail;
  assign w_last_beat  = (r_beat == c_BW'(c_NB - 1));
  assign w_last_addr  = (r_rd_addr == c_AW'(p_points - 1));
  assign w_base       = c_AW'({r_beat, 2'b00});

  // Memory has no reset so a mid-frame reset only forgets the partial bank.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      for (int j = 0; j < 4; j++) begin
        r_mem[r_wr_bank][w_base + c_AW'(j)]                  <= w_q[j];
        r_mem[r_wr_bank][w_base + c_AW'(j) + c_AW'(c_HALF)] <= w_q[j+4];
      end
    end
  end

  // Write and read always touch different banks, so both state updates may land together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_beat        <= '0;
      r_rd_addr     <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_state[0]    <= BANK_EMPTY;
      r_state[1]    <= BANK_EMPTY;
      r_frame_ready <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_last     <= 1'b0;
      r_rd_data     <= '0;
      r_sat         <= 1'b0;
    end else begin
      r_frame_ready <= w_wr && w_last_beat;
      r_rd_valid    <= w_rd;
      r_rd_last     <= w_rd && w_last_addr;
      if (w_wr) begin
        r_sat <= r_sat | (|w_sat);
        if (w_last_beat) begin
          r_beat             <= '0;
          r_state[r_wr_bank] <= BANK_FULL;
          r_wr_bank          <= ~r_wr_bank;
        end else begin
          r_beat             <= r_beat + 1'b1;
          r_state[r_wr_bank] <= BANK_FILLING;
        end
      end
      if (w_rd) begin
        r_rd_data <= r_mem[r_rd_bank][r_rd_addr];
        if (w_last_addr) begin
          r_rd_addr          <= '0;
          r_state[r_rd_bank] <= BANK_EMPTY;
          r_rd_bank          <= ~r_rd_bank;
        end else begin
          r_rd_addr          <= r_rd_addr + 1'b1;
          r_state[r_rd_bank] <= BANK_DRAINING;
        end
      end
    end
  end

  assign bus.o_ready       = !w_wr_blocked;
  assign bus.o_frame_ready = r_frame_ready;
  assign bus.o_rd_data     = r_rd_data;
  assign bus.o_rd_valid    = r_rd_valid;
  assign bus.o_rd_last     = r_rd_last;
  assign bus.o_sat         = C_SAT_EN && r_sat;

endmodule

// File: tb/tb_fft_stage_buffer.sv
// tb/tb_fft_stage_buffer.sv - self-checking bench for fft_stage_buffer against a frame-queue model.
module tb_fft_stage_buffer;

  localparam int IW = 8;
  localparam int PP = 3;
  localparam int W  = 14;
  localparam int P  = 32;
`ifdef FFT_BUF_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  fft_stage_buffer_if #(.p_inputWidth(IW), .p_PointPosition(PP)) bus();

  fft_stage_buffer #(
    .p_inputWidth(IW),
    .p_PointPosition(PP),
    .p_points(P)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [2*W-1:0] d_in [8];
  assign bus.i_r1_p = d_in[0];
  assign bus.i_r2_p = d_in[1];
  assign bus.i_r3_p = d_in[2];
  assign bus.i_r4_p = d_in[3];
  assign bus.i_r1_m = d_in[4];
  assign bus.i_r2_m = d_in[5];
  assign bus.i_r3_m = d_in[6];
  assign bus.i_r4_m = d_in[7];

  // Model: completed frames are a flat sample queue; a bank is busy per started 32-sample frame.
  logic [15:0] m_q[$];
  logic [15:0] m_part [P];
  int          m_beats, m_pos;
  bit          m_sat;
  bit          e_ready, e_fr, e_valid, e_last;
  logic [15:0] e_data;
  logic [15:0] got [P];

  function automatic logic [7:0] ref_q(input logic [W-1:0] c);
    int v;
    v = $signed(c);
    if (SAT_MODE && v > 127) return 8'h7F;
    if (SAT_MODE && v < -128) return 8'h80;
    return 8'(v);
  endfunction

  function automatic bit ref_oob(input logic [W-1:0] c);
    int v;
    v = $signed(c);
    return (v > 127) || (v < -128);
  endfunction

  function automatic logic [13:0] rand_comp();
    int v;
    if ($urandom_range(0, 1) == 1) begin
      v = int'($urandom_range(0, 255)) - 128;
      return 14'(v);
    end
    return 14'($urandom);
  endfunction

  task automatic rand_beat();
    for (int j = 0; j < 8; j++) d_in[j] = {rand_comp(), rand_comp()};
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_rd_en = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
    RST = 1'b0;
    m_q.delete();
    m_beats = 0;
    m_pos = 0;
    m_sat = 1'b0;
    e_ready = 1'b1;
    e_fr = 1'b0;
    e_valid = 1'b0;
    e_last = 1'b0;
  endtask

  task automatic do_cycle(input bit v, input bit rd);
    bit acc, rdo;
    bus.i_valid = v;
    bus.i_rd_en = rd;
    acc = v && (m_q.size() <= P);
    rdo = rd && (m_q.size() > 0);
    e_valid = rdo;
    e_last = 1'b0;
    e_fr = 1'b0;
    if (rdo) begin
      e_data = m_q.pop_front();
      e_last = (m_pos == P - 1);
      m_pos = (m_pos + 1) % P;
    end
    if (acc) begin
      for (int j = 0; j < 4; j++) begin
        m_part[4*m_beats + j]       = {ref_q(d_in[j][2*W-1:W]), ref_q(d_in[j][W-1:0])};
        m_part[4*m_beats + j + P/2] = {ref_q(d_in[j+4][2*W-1:W]), ref_q(d_in[j+4][W-1:0])};
      end
      for (int j = 0; j < 8; j++)
        if (SAT_MODE && (ref_oob(d_in[j][2*W-1:W]) || ref_oob(d_in[j][W-1:0]))) m_sat = 1'b1;
      m_beats++;
      if (m_beats == P / 8) begin
        for (int a = 0; a < P; a++) m_q.push_back(m_part[a]);
        m_beats = 0;
        e_fr = 1'b1;
      end
    end
    e_ready = (m_q.size() <= P);
    @(posedge CLK);
    #1;
    bus.i_valid = 1'b0;
    bus.i_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if ({bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_sat} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 10000", {bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_sat});
    end
    n_checks++;
    if (bus.o_rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h expected 0000", bus.o_rd_data);
    end
  endtask

  task automatic test_basic_frame();
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        d_in[j]   = {14'(j + 1), 14'd0};
        d_in[j+4] = {14'(-(j + 1)), 14'd0};
      end
      do_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_sat} !== {e_ready, e_fr, e_valid, e_last, m_sat}) begin
        n_fail++;
        $display("FAIL basic_write_flags beat %0d: got %b expected %b", k, {bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_sat}, {e_ready, e_fr, e_valid, e_last, m_sat});
      end
    end
    for (int i = 0; i < P; i++) begin
      do_cycle(1'b0, 1'b1);
      got[i] = bus.o_rd_data;
      n_checks++;
      if ({bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last} !== {e_ready, e_fr, e_valid, e_last} || (e_valid && bus.o_rd_data !== e_data)) begin
        n_fail++;
        $display("FAIL basic_read addr %0d: got %b/%h expected %b/%h", i, {bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last}, bus.o_rd_data, {e_ready, e_fr, e_valid, e_last}, e_data);
      end
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (got[j] !== {8'(j + 1), 8'h00} || got[j+16] !== {8'(-(j + 1)), 8'h00}) begin
        n_fail++;
        $display("FAIL basic_layout j %0d: got %h/%h expected %h/%h", j, got[j], got[j+16], {8'(j + 1), 8'h00}, {8'(-(j + 1)), 8'h00});
      end
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) d_in[j] = '0;
      if (k == 0) begin
        d_in[0] = {14'd200, 14'd0};
        d_in[1] = {14'h3F00, 14'd0};
      end
      do_cycle(1'b1, 1'b0);
    end
    n_checks++;
    if (bus.o_sat !== SAT_MODE) begin
      n_fail++;
      $display("FAIL sat_flag: got %b expected %b", bus.o_sat, SAT_MODE);
    end
    for (int i = 0; i < P; i++) begin
      do_cycle(1'b0, 1'b1);
      got[i] = bus.o_rd_data;
      n_checks++;
      if (bus.o_rd_valid !== e_valid || bus.o_rd_data !== e_data || bus.o_sat !== m_sat) begin
        n_fail++;
        $display("FAIL sat_read addr %0d: got %b/%h expected %b/%h", i, bus.o_rd_valid, bus.o_rd_data, e_valid, e_data);
      end
    end
    n_checks++;
    if (got[0] !== (SAT_MODE ? 16'h7F00 : 16'hC800) || got[1] !== (SAT_MODE ? 16'h8000 : 16'h0000)) begin
      n_fail++;
      $display("FAIL sat_values: got %h/%h expected %h/%h", got[0], got[1], SAT_MODE ? 16'h7F00 : 16'hC800, SAT_MODE ? 16'h8000 : 16'h0000);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    for (int k = 0; k < 9; k++) begin
      rand_beat();
      do_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bus.o_ready, bus.o_frame_ready} !== {e_ready, e_fr}) begin
        n_fail++;
        $display("FAIL bp_write beat %0d: got %b expected %b", k, {bus.o_ready, bus.o_frame_ready}, {e_ready, e_fr});
      end
    end
    n_checks++;
    if (bus.o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_blocked: got %b expected 0", bus.o_ready);
    end
    for (int i = 0; i < 2 * P; i++) begin
      do_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_ready, bus.o_rd_valid, bus.o_rd_last} !== {e_ready, e_valid, e_last} || bus.o_rd_data !== e_data) begin
        n_fail++;
        $display("FAIL bp_read %0d: got %b/%h expected %b/%h", i, {bus.o_ready, bus.o_rd_valid, bus.o_rd_last}, bus.o_rd_data, {e_ready, e_valid, e_last}, e_data);
      end
      if (i == P - 1) begin
        n_checks++;
        if (bus.o_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_release: got %b expected 1", bus.o_ready);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      rand_beat();
      do_cycle(1'b1, 1'b0);
    end
    for (int i = 0; i < P; i++) begin
      rand_beat();
      do_cycle((i < 3) || (i == P - 1), 1'b1);
      n_checks++;
      if ({bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last} !== {e_ready, e_fr, e_valid, e_last} || bus.o_rd_data !== e_data) begin
        n_fail++;
        $display("FAIL same_cycle %0d: got %b/%h expected %b/%h", i, {bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last}, bus.o_rd_data, {e_ready, e_fr, e_valid, e_last}, e_data);
      end
    end
    n_checks++;
    if ({bus.o_ready, bus.o_frame_ready, bus.o_rd_last} !== 3'b111) begin
      n_fail++;
      $display("FAIL same_cycle_final: got %b expected 111", {bus.o_ready, bus.o_frame_ready, bus.o_rd_last});
    end
    for (int i = 0; i < P + 1; i++) begin
      do_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_ready, bus.o_rd_valid, bus.o_rd_last} !== {e_ready, e_valid, e_last} || (e_valid && bus.o_rd_data !== e_data)) begin
        n_fail++;
        $display("FAIL same_cycle_bank1 %0d: got %b/%h expected %b/%h", i, {bus.o_ready, bus.o_rd_valid, bus.o_rd_last}, bus.o_rd_data, {e_ready, e_valid, e_last}, e_data);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      rand_beat();
      do_cycle(1'b1, 1'b0);
    end
    do_reset(1);
    n_checks++;
    if ({bus.o_ready, bus.o_frame_ready, bus.o_rd_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b expected 100", {bus.o_ready, bus.o_frame_ready, bus.o_rd_valid});
    end
    for (int k = 0; k < 4; k++) begin
      rand_beat();
      do_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bus.o_ready, bus.o_frame_ready} !== {e_ready, e_fr}) begin
        n_fail++;
        $display("FAIL midreset_write beat %0d: got %b expected %b", k, {bus.o_ready, bus.o_frame_ready}, {e_ready, e_fr});
      end
    end
    for (int i = 0; i < P; i++) begin
      do_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_rd_valid, bus.o_rd_last} !== {e_valid, e_last} || bus.o_rd_data !== e_data) begin
        n_fail++;
        $display("FAIL midreset_read %0d: got %b/%h expected %b/%h", i, {bus.o_rd_valid, bus.o_rd_last}, bus.o_rd_data, {e_valid, e_last}, e_data);
      end
    end
  endtask

  task automatic test_idle_read();
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_rd_valid, bus.o_rd_last} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_read %0d: got %b expected 00", i, {bus.o_rd_valid, bus.o_rd_last});
      end
    end
    for (int k = 0; k < 4; k++) begin
      rand_beat();
      do_cycle(1'b1, 1'b0);
    end
    for (int i = 0; i < P; i++) begin
      do_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.o_rd_valid, bus.o_rd_last} !== {e_valid, e_last} || bus.o_rd_data !== e_data) begin
        n_fail++;
        $display("FAIL idle_then_read %0d: got %b/%h expected %b/%h", i, {bus.o_rd_valid, bus.o_rd_last}, bus.o_rd_data, {e_valid, e_last}, e_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      bit v, rd;
      rand_beat();
      v  = (i < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      rd = (i < 4) ? 1'b0 : (i < 100) ? 1'b1 : ((i < 300) ? 1'($urandom_range(0, 1)) : 1'b1);
      if (i >= 300) v = 1'b0;
      do_cycle(v, rd);
      n_checks++;
      if ({bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_sat} !== {e_ready, e_fr, e_valid, e_last, m_sat} || (e_valid && bus.o_rd_data !== e_data)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: got %b/%h expected %b/%h", i, {bus.o_ready, bus.o_frame_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_sat}, bus.o_rd_data, {e_ready, e_fr, e_valid, e_last, m_sat}, e_data);
      end
    end
    n_checks++;
    if (m_q.size() != 0 || bus.o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d left/ready %b expected 0/1", m_q.size(), bus.o_ready);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_rd_en = 1'b0;
    for (int j = 0; j < 8; j++) d_in[j] = '0;
    test_reset();
    test_basic_frame();
    test_saturation();
    test_backpressure();
    test_same_cycle();
    test_reset_midframe();
    test_idle_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_stage_buffer.md
FFT_STAGE_BUFFER -- requirements
Module: fft_stage_buffer

Interface
REQ-001 Parameter p_inputWidth, default 8, signed component width of stored samples.
REQ-002 Parameter p_PointPosition, default 3, fractional bits; multiplier component width W=2*p_inputWidth-p_PointPosition+1 (14).
REQ-003 Parameter p_points, default 32, FFT points per frame.
REQ-004 Ports: CLK  in  1  single clock; RST  in  1  synchronous, active-high reset.
REQ-005 i_valid  in  1  beat of four butterfly results present.
REQ-006 o_ready  out  1  beat accepted when i_valid&&o_ready.
REQ-007 i_r1_p,i_r1_m..i_r4_p,i_r4_m  in  2W each  complex results; [2W-1:W] real, [W-1:0] imag, two's complement, p_PointPosition fractional bits.
REQ-008 o_frame_ready  out  1  one-cycle pulse when a bank completes.
REQ-009 i_rd_en  in  1  request next stored sample.
REQ-010 o_rd_data  out  2*p_inputWidth  {real,imag} sample; o_rd_valid  out  1; o_rd_last  out  1  with address p_points-1.
REQ-011 o_sat  out  1  sticky: any component saturated (SAT_EN only).

Function
REQ-012 Two banks (ping-pong) of p_points x 2*p_inputWidth words.
REQ-013 Each component requantized W->p_inputWidth with no shift: same point position, upper bits reduced.
REQ-014 Accepted beat k (0..p_points/8-1) writes rj_p to address 4k+j-1 and rj_m to 4k+j-1+p_points/2, j=1..4.
REQ-015 Beat counter wraps after p_points/8 beats; write bank then marked FULL, o_frame_ready pulses the next cycle, writing moves to other bank.
REQ-016 Per-bank state EMPTY->FILLING (first beat)->FULL (last beat)->DRAINING (first read)->EMPTY (read of address p_points-1).
REQ-017 o_ready=0 exactly when the current write bank is FULL or DRAINING; i_valid with o_ready=0 is ignored.
REQ-018 Reads serve the oldest FULL/DRAINING bank, addresses 0..p_points-1 ascending; o_rd_data/o_rd_valid one cycle after i_rd_en.
REQ-019 i_rd_en with no FULL/DRAINING bank is ignored; o_rd_valid stays 0.
REQ-020 Same-cycle final write of one bank and final read of the other: both take effect; o_ready stays 1.
REQ-021 Throughput: one beat per cycle write, one sample per cycle read, sustained without bubbles.

Reset
REQ-022 RST clears beat/read counters, bank states to EMPTY, bank selects to 0, o_sat; outputs o_ready=1, o_frame_ready=0, o_rd_valid=0, o_rd_last=0, o_rd_data=0.
REQ-023 RST mid-frame discards partial banks; memory contents not cleared.

Configuration
REQ-024 Macro FFT_BUF_SAT_EN defined: components >2^(p_inputWidth-1)-1 clamp to max, <-2^(p_inputWidth-1) clamp to min, o_sat set sticky.
REQ-025 Macro FFT_BUF_SAT_EN undefined: low p_inputWidth bits kept (wrap), o_sat tied 0.

Structure
REQ-026 Package fft_pkg holds W derivation, p_points default, real/imag packing slice constants, bank state encoding.
REQ-027 One sub-module cplx_requant: combinational 2W->2*p_inputWidth requantizer with saturate flag, instantiated eight times.

Verification
REQ-028 Reset, then 4 beats with rj_p real=j, rj_m real=-j -> o_frame_ready pulse after beat 4; reading 32 gives addr 0..3 real 1..4, addr 16..19 real -1..-4 (0xFF..0xFC), o_rd_last at addr 31.
REQ-029 Real component 14'd200 with FFT_BUF_SAT_EN -> stored 8'h7F, o_sat=1; 14'h3F00 -> 8'h80; without macro 14'd200 -> 8'hC8, o_sat=0.
REQ-030 8 beats with no reads -> o_ready=0 after beat 8; 9th i_valid ignored; after 32 reads o_ready=1.
REQ-031 Final read of bank 0 in same cycle as final write of bank 1 -> both banks advance, o_ready stays 1, next reads return bank 1 data.
REQ-032 RST after 2 beats -> o_ready=1, no o_frame_ready; next 4 beats complete a frame at addresses 0..31.
REQ-033 i_rd_en with both banks EMPTY -> o_rd_valid=0, read address unchanged.
